ccff_loader: RTL and testbench

- Drives the fabric configuration chains from a streamed bitstream source. It is the writer end of the ccff_head / config_enable / CFG_DONE interface that the fabric consumes.
- Accepts one bit per chain per transfer over a valid/ready stream. It shifts each bit into the heads of NUM_CHAINS parallel chains of CHAIN_LEN flops.
- After loading, it waits a settle interval and then raises cfg_done. It aborts with an error if the source stalls too long.
- Sits between the bitstream source (DMA or JTAG bridge) and fpga_top.

---
 rtl/ccff_loader.sv | 151 +++++++++++++++
 tb/tb_ccff_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// Purpose : streams a bitstream into NUM_CHAINS parallel config chains, then settles and raises cfg_done.
// Latency : an accepted slice appears on ccff_head (ccff_shift=1) one prog_clock later; cfg_done SETTLE_CYC+1 cycles after the last slice.
// Backpressure: bs_ready is high only in LOAD and depends on state alone; a source stalled TIMEOUT cycles aborts to ERROR.
//
// Ports:
//   prog_clock, global_reset (async, active low)
//   start                      : begin a load (honoured in IDLE, DONE, ERROR)
//   bs_valid/bs_data/bs_ready  : bitstream slice stream, bit i feeds chain i
//   ccff_head/ccff_shift       : registered serial data and shift strobe to the chain heads
//   ccff_tail                  : chain outputs (not used by the control logic)
//   config_enable, cfg_done    : fabric configuration mode and completion
//   busy, err, bit_count       : status; bit_count counts slices accepted in the current load
module ccff_loader #(
  parameter int NUM_CHAINS = 10,
  parameter int CHAIN_LEN  = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 16
) (
  input  logic                  prog_clock,
  input  logic                  global_reset,
  input  logic                  start,
  input  logic                  bs_valid,
  input  logic [NUM_CHAINS-1:0] bs_data,
  output logic                  bs_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  config_enable,
  output logic                  cfg_done,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int STALL_W  = $clog2(TIMEOUT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(CHAIN_LEN - 1);
  localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state, nxt_state;
  logic [STALL_W-1:0]    stall_cnt, nxt_stall;
  logic [SETTLE_W-1:0]   settle_cnt, nxt_settle;
  logic [NUM_CHAINS-1:0] nxt_head;
  logic                  nxt_shift, nxt_cen, nxt_done, nxt_err;
  logic [CNT_W-1:0]      nxt_count;
  logic                  xfer;

  // The tail is carried only so the port list mirrors the fabric side.
  logic unused_tail;
  assign unused_tail = ^ccff_tail;

  assign bs_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_SETTLE);
  assign xfer     = bs_valid && bs_ready;

  always_ff @(posedge prog_clock or negedge global_reset) begin
    if (!global_reset) begin
      state         <= S_IDLE;
      ccff_head     <= '0;
      ccff_shift    <= 1'b0;
      config_enable <= 1'b0;
      cfg_done      <= 1'b0;
      err           <= 1'b0;
      bit_count     <= '0;
      stall_cnt     <= '0;
      settle_cnt    <= '0;
    end else begin
      state         <= nxt_state;
      ccff_head     <= nxt_head;
      ccff_shift    <= nxt_shift;
      config_enable <= nxt_cen;
      cfg_done      <= nxt_done;
      err           <= nxt_err;
      bit_count     <= nxt_count;
      stall_cnt     <= nxt_stall;
      settle_cnt    <= nxt_settle;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_head   = ccff_head;   // head only moves on an accepted slice
    nxt_shift  = 1'b0;
    nxt_cen    = config_enable;
    nxt_done   = cfg_done;
    nxt_err    = err;
    nxt_count  = bit_count;
    nxt_stall  = stall_cnt;
    nxt_settle = settle_cnt;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          nxt_state = S_LOAD;
          nxt_count = '0;
          nxt_cen   = 1'b1;
          nxt_done  = 1'b0;
          nxt_err   = 1'b0;
          nxt_stall = '0;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          // A slice arriving on the would-be timeout cycle still wins.
          nxt_head  = bs_data;
          nxt_shift = 1'b1;
          nxt_stall = '0;
          nxt_count = (bit_count == CNT_FULL) ? bit_count : bit_count + 1'b1;
          if (bit_count == CNT_LAST) begin
            nxt_state  = S_SETTLE;
            nxt_settle = '0;
          end
        end else if (stall_cnt == STALL_LAST) begin
          nxt_state = S_ERROR;
          nxt_err   = 1'b1;
          nxt_cen   = 1'b0;
          nxt_stall = '0;
        end else begin
          nxt_stall = stall_cnt + 1'b1;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          nxt_state = S_DONE;
          nxt_done  = 1'b1;
        end else begin
          nxt_settle = settle_cnt + 1'b1;
        end
      end

      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Purpose : self-checking bench for ccff_loader with a small chain (8 flops x 10 chains).
// Latency : checks one-cycle head latency and cfg_done five cycles after the last slice.
// Backpressure: exercises source gaps, stall timeout and the timeout boundary.
module tb_ccff_loader;

  localparam int NC = 10;
  localparam int CL = 8;
  localparam int SC = 4;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          prog_clock = 1'b0;
  logic          global_reset;
  logic          start;
  logic          bs_valid;
  logic [NC-1:0] bs_data;
  logic          bs_ready;
  logic [NC-1:0] ccff_head;
  logic          ccff_shift;
  logic [NC-1:0] ccff_tail;
  logic          config_enable;
  logic          cfg_done;
  logic          busy;
  logic          err;
  logic [CW-1:0] bit_count;

  ccff_loader #(
    .NUM_CHAINS(NC), .CHAIN_LEN(CL), .SETTLE_CYC(SC), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .prog_clock(prog_clock), .global_reset(global_reset), .start(start),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_shift(ccff_shift), .ccff_tail(ccff_tail),
    .config_enable(config_enable), .cfg_done(cfg_done), .busy(busy),
    .err(err), .bit_count(bit_count)
  );

  always #5 prog_clock = ~prog_clock;

  typedef struct {
    logic [NC-1:0] data;
    int            gap;        // idle cycles before this slice (gap runs only)
    logic [CW-1:0] exp_count;  // bit_count after this slice
  } vec_t;

  vec_t          vecs [CL];
  int            checks = 0;
  int            errors = 0;
  logic [NC-1:0] sb_q [$];
  logic [NC-1:0] sb_exp;
  logic [NC-1:0] model [CL];
  logic [NC-1:0] snap [CL];

  assign ccff_tail = model[CL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and chain model: every shift strobe consumes one expected slice.
  always @(negedge prog_clock) begin
    if (global_reset && ccff_shift) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_shift actual=%0h required=none", ccff_head);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_head", 32'(ccff_head), 32'(sb_exp));
      end
      for (int k = CL - 1; k > 0; k--) model[k] = model[k-1];
      model[0] = ccff_head;
    end
  end

  task automatic tick();
    @(posedge prog_clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_slice(input logic [NC-1:0] d);
    bs_valid = 1'b1;
    bs_data  = d;
    for (int n = 0; n < 50 && !bs_ready; n++) tick();
    chk("send_ready", 32'(bs_ready), 32'd1);
    if (bs_ready) sb_q.push_back(d);
    tick();
  endtask

  task automatic clear_model();
    for (int k = 0; k < CL; k++) model[k] = '0;
  endtask

  task automatic apply_table(input bit gaps);
    for (int i = 0; i < CL; i++) begin
      if (gaps && vecs[i].gap > 0) begin
        bs_valid = 1'b0;
        for (int g = 0; g < vecs[i].gap; g++) begin
          tick();
          chk("gap_shift", 32'(ccff_shift), 32'd0);
          chk("gap_head", 32'(ccff_head), 32'(vecs[i-1].data));
        end
      end
      send_slice(vecs[i].data);
      chk("head", 32'(ccff_head), 32'(vecs[i].data));
      chk("shift", 32'(ccff_shift), 32'd1);
      chk("count", 32'(bit_count), 32'(vecs[i].exp_count));
      chk("cen_load", 32'(config_enable), 32'd1);
    end
    bs_valid = 1'b0;
  endtask

  // Called right after the final slice edge: cfg_done rises after the 4th further edge.
  task automatic settle_check();
    chk("settle_ready", 32'(bs_ready), 32'd0);
    for (int c = 1; c <= SC; c++) begin
      tick();
      chk("cfg_done_t", 32'(cfg_done), (c == SC) ? 32'd1 : 32'd0);
      chk("cen_settle", 32'(config_enable), 32'd1);
    end
    chk("done_count", 32'(bit_count), 32'(CL));
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic model_check(input bit vs_snap);
    for (int k = 0; k < CL; k++) begin
      chk("chain", 32'(model[k]), 32'(vecs[CL-1-k].data));
      if (vs_snap) chk("chain_vs_nogap", 32'(model[k]), 32'(snap[k]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_head"}, 32'(ccff_head), 32'd0);
    chk({tag, "_shift"}, 32'(ccff_shift), 32'd0);
    chk({tag, "_ready"}, 32'(bs_ready), 32'd0);
    chk({tag, "_cen"}, 32'(config_enable), 32'd0);
    chk({tag, "_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_count"}, 32'(bit_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CL; i++) begin
      vecs[i].data      = NC'(1 << i);
      vecs[i].gap       = (i == 4) ? 3 : 0;
      vecs[i].exp_count = CW'(i + 1);
    end
    clear_model();
    global_reset = 1'b0;
    start        = 1'b0;
    bs_valid     = 1'b0;
    bs_data      = '0;

    // Reset state
    #12;
    chk_all_zero("reset");
    global_reset = 1'b1;
    tick();
    chk("idle_ready", 32'(bs_ready), 32'd0);

    // 1: nominal load
    pulse_start();
    chk("load_ready", 32'(bs_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cen", 32'(config_enable), 32'd1);
    apply_table(1'b0);
    settle_check();
    model_check(1'b0);
    for (int k = 0; k < CL; k++) snap[k] = model[k];

    // 5b + 2: restart from DONE, then a load with a 3-cycle gap
    clear_model();
    pulse_start();
    chk("restart_done", 32'(cfg_done), 32'd0);
    chk("restart_count", 32'(bit_count), 32'd0);
    apply_table(1'b1);
    settle_check();
    model_check(1'b1);

    // 5a: start ignored in LOAD and SETTLE
    pulse_start();
    for (int i = 0; i < CL; i++) begin
      start = (i == 2);
      send_slice(vecs[i].data);
      chk("ign_count", 32'(bit_count), 32'(i + 1));
    end
    start    = 1'b0;
    bs_valid = 1'b0;
    for (int c = 1; c <= SC; c++) begin
      start = (c == 1);
      tick();
      chk("ign_cfg_done", 32'(cfg_done), (c == SC) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    tick();
    chk("hold_done", 32'(cfg_done), 32'd1);
    chk("hold_count", 32'(bit_count), 32'(CL));

    // 3: stall timeout
    pulse_start();
    for (int i = 0; i < 3; i++) send_slice(vecs[i].data);
    bs_valid = 1'b0;
    for (int s = 1; s <= TO; s++) begin
      tick();
      if (s >= TO - 1) chk("stall_err", 32'(err), (s == TO) ? 32'd1 : 32'd0);
    end
    chk("err_cen", 32'(config_enable), 32'd0);
    chk("err_ready", 32'(bs_ready), 32'd0);
    chk("err_count", 32'(bit_count), 32'd3);
    chk("err_busy", 32'(busy), 32'd0);
    pulse_start();
    chk("reload_err", 32'(err), 32'd0);
    chk("reload_ready", 32'(bs_ready), 32'd1);
    chk("reload_count", 32'(bit_count), 32'd0);

    // 6: timeout boundary, 15 stalls then a slice on cycle 16
    for (int s = 0; s < TO - 1; s++) tick();
    chk("bound_err_pre", 32'(err), 32'd0);
    for (int i = 0; i < CL; i++) send_slice(vecs[i].data);
    bs_valid = 1'b0;
    chk("bound_err_post", 32'(err), 32'd0);
    settle_check();

    // 4: asynchronous reset mid-load
    pulse_start();
    for (int i = 0; i < 5; i++) send_slice(vecs[i].data);
    #3;
    global_reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    sb_q.delete();
    #3;
    global_reset = 1'b1;
    bs_valid = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bs_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_count", 32'(bit_count), 32'd0);
    pulse_start();
    for (int i = 0; i < CL; i++) send_slice(vecs[i].data);
    bs_valid = 1'b0;
    settle_check();

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
